gui_command_decoder: RTL and testbench
======================================

GUI_COMMAND_DECODER -- requirements
Module: gui_command_decoder

Interface
REQ-001 Parameter HEADER, default 8'hA5: frame start byte.
REQ-002 Parameter TIMEOUT_CYCLES, default 25_000_000: watchdog period (0.5 s at 50 MHz).
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk_50  input  1: system clock, 50 MHz, all logic on rising edge.
REQ-005 reset  input  1: synchronous active-high reset.
REQ-006 byte_data  input  8: received UART byte from upstream receiver.
REQ-007 byte_valid  input  1: upstream byte available; may stay high across idle periods.
REQ-008 byte_ready  output  1: decoder can accept a byte.
REQ-009 obstacle  input  1: proximity sensor asserted, already synchronised.
REQ-010 motor_dir  output  3: 0 stop, 1 forward, 2 reverse, 3 left, 4 right.
REQ-011 motor_speed  output  8: commanded duty, 0-255.
REQ-012 cmd_strobe  output  1: one-cycle pulse per applied good frame.
REQ-013 frame_error  output  1: one-cycle pulse on a bad frame.
REQ-014 timeout  output  1: watchdog expired; level.

Function
REQ-015 Byte acceptance: a byte is accepted on a cycle with byte_valid && byte_ready.
REQ-016 After an acceptance, byte_ready drops the next cycle and stays low until byte_valid is sampled low; then it returns high. Each valid assertion yields exactly one accepted byte.
REQ-017 Frame format: HEADER, CMD, SPD, CHK, where CHK = CMD ^ SPD (8-bit XOR).
REQ-018 FSM states: S_HDR, S_CMD, S_SPD, S_CHK, S_APPLY.
REQ-019 S_HDR: an accepted byte equal to HEADER moves to S_CMD; other bytes are discarded silently with no error.
REQ-020 S_CMD: the accepted byte is latched and moves to S_SPD; a HEADER value here is treated as data.
REQ-021 S_SPD: the accepted byte is latched and moves to S_CHK.
REQ-022 S_CHK, good checksum and CMD<=4: move to S_APPLY. Bad checksum or CMD>4: frame_error pulses the next cycle, return to S_HDR, outputs unchanged.
REQ-023 S_APPLY, one cycle: store the command, cmd_strobe=1, return to S_HDR. motor outputs update exactly one cycle after the CHK byte is accepted.
REQ-024 CMD=0 forces stored speed 0 regardless of SPD.
REQ-025 Obstacle override: while obstacle=1 and the stored dir=forward, motor_dir=0 and motor_speed=0 (registered, one-cycle latency). When obstacle falls, the stored command is restored the next cycle. Reverse, left and right are unaffected.
REQ-026 A good forward frame applied while obstacle=1 is stored and cmd_strobe pulses, but the outputs stay at stop until obstacle falls.
REQ-027 If byte_valid is low in any non-S_HDR state, the FSM waits; there is no inter-byte timeout.

Reset
REQ-028 Reset values: FSM=S_HDR, byte_ready=1, motor_dir=0, motor_speed=0, cmd_strobe=0, frame_error=0, timeout=0, latched bytes=0, watchdog counter=0.
REQ-029 Reset mid-frame discards the partial frame; the next frame must start with HEADER.

Configuration
REQ-030 Macro CMD_WATCHDOG_EN. Defined: a counter increments each cycle and clears on every S_APPLY.
REQ-031 With CMD_WATCHDOG_EN, at count TIMEOUT_CYCLES-1 the stored command becomes stop/0 and timeout=1 on the next cycle. timeout holds until the next good frame clears it in S_APPLY. The counter saturates, with no wrap.
REQ-032 Undefined: no counter is present, timeout is tied 0, and the stored command persists indefinitely.

Verification
REQ-033 Frame A5 01 80 81 -> motor_dir=1, motor_speed=0x80, one cmd_strobe, frame_error never high.
REQ-034 Frame A5 02 40 00 (bad CHK) -> frame_error single pulse; outputs keep their prior value; next A5 03 20 23 applies dir=3, speed=0x20.
REQ-035 byte_valid held high 100 cycles carrying A5 -> exactly one byte accepted; byte_ready low until byte_valid drops.
REQ-036 Forward 0x80 applied, obstacle=1 -> dir=0, speed=0 next cycle; obstacle=0 -> dir=1, speed=0x80 next cycle; reverse 0x80 with obstacle=1 -> unaffected.
REQ-037 CMD_WATCHDOG_EN with TIMEOUT_CYCLES=100, frame A5 04 10 14 then idle -> dir=0, speed=0, timeout=1 after 100 cycles; next good frame -> timeout=0.
REQ-038 Reset asserted after A5 01 -> next bytes 80 81 are discarded and the outputs stay stop/0.

Source files
------------

// File: rtl/gui_command_decoder.sv
// gui_command_decoder: turns 4-byte UART frames (HEADER, CMD, SPD, CHK = CMD ^ SPD) into a motor direction/speed command.
// Latency: the motor outputs, cmd_strobe and frame_error are valid in the cycle after the CHK byte is accepted.
// Backpressure: one byte per byte_valid assertion. byte_ready drops after an accept and returns after byte_valid is seen low.
// Optional feature: define CMD_WATCHDOG_EN to add a command watchdog. It forces stop/0 and raises timeout when no good frame arrives in time.
module gui_command_decoder #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       obstacle,
  output logic [2:0] motor_dir,
  output logic [7:0] motor_speed,
  output logic       cmd_strobe,
  output logic       frame_error,
  output logic       timeout
);

  localparam logic [2:0] DIR_STOP    = 3'd0;
  localparam logic [2:0] DIR_FORWARD = 3'd1;
  localparam logic [7:0] CMD_MAX     = 8'd4;

  typedef enum logic [2:0] {
    S_HDR,
    S_CMD,
    S_SPD,
    S_CHK,
    S_APPLY
  } state_t;

  state_t     state_q, state_d;
  logic       ready_q, ready_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] spd_q, spd_d;
  logic [2:0] st_dir_q, st_dir_d;
  logic [7:0] st_spd_q, st_spd_d;
  logic [2:0] dir_q, dir_d;
  logic [7:0] speed_q, speed_d;
  logic       err_q, err_d;

  logic       accept;
  logic       frame_ok;

  assign accept   = byte_valid && ready_q;
  // The checksum byte is compared against the bytes latched earlier in this frame.
  assign frame_ok = (byte_data == (cmd_q ^ spd_q)) && (cmd_q <= CMD_MAX);

`ifdef CMD_WATCHDOG_EN
  // The counter only has to reach TIMEOUT_CYCLES-1, where it saturates. TIMEOUT_CYCLES must be at least 1.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`else
  // Without the watchdog the timeout period has no effect.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  // Next-state logic for the handshake, the frame FSM, the stored command, the watchdog and the obstacle override.
  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    cmd_d    = cmd_q;
    spd_d    = spd_q;
    st_dir_d = st_dir_q;
    st_spd_d = st_spd_q;
    err_d    = 1'b0;
`ifdef CMD_WATCHDOG_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif

    // After an accept, wait for the upstream valid to drop so that a held valid yields only one byte.
    if (accept) begin
      ready_d = 1'b0;
    end else if (!ready_q && !byte_valid) begin
      ready_d = 1'b1;
    end

`ifdef CMD_WATCHDOG_EN
    // A good frame restarts the watchdog. Expiry forces stop/0 once, and the counter then stays saturated.
    if (state_q == S_APPLY) begin
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else begin
      if (cnt_q != CNT_LAST) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (!timeout_q) begin
        timeout_d = 1'b1;
        st_dir_d  = DIR_STOP;
        st_spd_d  = 8'd0;
      end
    end
`endif

    // The frame FSM. Storing a command here takes priority over a watchdog expiry on the same edge.
    case (state_q)
      S_HDR: begin
        if (accept && (byte_data == HEADER)) begin
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (accept) begin
          cmd_d   = byte_data;
          state_d = S_SPD;
        end
      end
      S_SPD: begin
        if (accept) begin
          spd_d   = byte_data;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (accept) begin
          if (frame_ok) begin
            // Store on the CHK edge so the outputs change in the S_APPLY cycle, together with cmd_strobe.
            state_d  = S_APPLY;
            st_dir_d = cmd_q[2:0];
            st_spd_d = (cmd_q == 8'd0) ? 8'd0 : spd_q;
          end else begin
            err_d   = 1'b1;
            state_d = S_HDR;
          end
        end
      end
      S_APPLY: begin
        state_d = S_HDR;
      end
      default: begin
        state_d = S_HDR;
      end
    endcase

    // While an obstacle is present, a forward command is masked to stop. The stored command is kept.
    if (obstacle && (st_dir_d == DIR_FORWARD)) begin
      dir_d   = DIR_STOP;
      speed_d = 8'd0;
    end else begin
      dir_d   = st_dir_d;
      speed_d = st_spd_d;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q  <= S_HDR;
      ready_q  <= 1'b1;
      cmd_q    <= 8'd0;
      spd_q    <= 8'd0;
      st_dir_q <= DIR_STOP;
      st_spd_q <= 8'd0;
      dir_q    <= DIR_STOP;
      speed_q  <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      cmd_q    <= cmd_d;
      spd_q    <= spd_d;
      st_dir_q <= st_dir_d;
      st_spd_q <= st_spd_d;
      dir_q    <= dir_d;
      speed_q  <= speed_d;
      err_q    <= err_d;
    end
  end

`ifdef CMD_WATCHDOG_EN
  // Watchdog counter and timeout flag.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign byte_ready  = ready_q;
  assign motor_dir   = dir_q;
  assign motor_speed = speed_q;
  assign cmd_strobe  = (state_q == S_APPLY);
  assign frame_error = err_q;

endmodule

// File: tb/tb_gui_command_decoder.sv
// Testbench for gui_command_decoder: table of frames plus hand-written sequences for the handshake, obstacle, reset and watchdog cases.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled then or on the falling edge.
// Byte sends wait for byte_ready with a bounded cycle budget.
module tb_gui_command_decoder;

  logic       clk_50;
  logic       reset;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       obstacle;
  logic [2:0] motor_dir;
  logic [7:0] motor_speed;
  logic       cmd_strobe;
  logic       frame_error;
  logic       timeout;

  int tests_run;
  int tests_failed;

  gui_command_decoder #(
    .HEADER        (8'hA5),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_50     (clk_50),
    .reset      (reset),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .obstacle   (obstacle),
    .motor_dir  (motor_dir),
    .motor_speed(motor_speed),
    .cmd_strobe (cmd_strobe),
    .frame_error(frame_error),
    .timeout    (timeout)
  );

  initial begin
    clk_50 = 1'b0;
    forever #5 clk_50 = ~clk_50;
  end

  typedef struct packed {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    logic       obs;
    logic [2:0] exp_dir;
    logic [7:0] exp_spd;
    logic       exp_strobe;
    logic       exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  // Waits for byte_ready, presents one byte and drops valid right after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (!byte_ready && n < 50) begin
      tick();
      n++;
    end
    if (!byte_ready) check("ready_wait", 32'(byte_ready), 32'd1);
    byte_data  = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  initial begin
    int acc;
    int n;
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    byte_data    = 8'h00;
    byte_valid   = 1'b0;
    obstacle     = 1'b0;

    //          b0     b1     b2     b3     obs   dir   spd    strb  err
    vecs[0] = '{8'hA5, 8'h01, 8'h80, 8'h81, 1'b0, 3'd1, 8'h80, 1'b1, 1'b0};
    vecs[1] = '{8'hA5, 8'h02, 8'h40, 8'h00, 1'b0, 3'd1, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'hA5, 8'h03, 8'h20, 8'h23, 1'b0, 3'd3, 8'h20, 1'b1, 1'b0};
    vecs[3] = '{8'hA5, 8'h00, 8'h55, 8'h55, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'hA5, 8'h05, 8'h10, 8'h15, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{8'hA5, 8'h04, 8'hFF, 8'hFB, 1'b0, 3'd4, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'hA5, 8'h01, 8'h80, 8'h81, 1'b1, 3'd0, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'hA5, 8'h02, 8'h80, 8'h82, 1'b1, 3'd2, 8'h80, 1'b1, 1'b0};
    vecs[8] = '{8'hA5, 8'hA5, 8'h11, 8'hB4, 1'b0, 3'd2, 8'h80, 1'b0, 1'b1};

    tick();
    tick();
    reset = 1'b0;
    check("rst_ready", 32'(byte_ready), 32'd1);
    check("rst_dir", 32'(motor_dir), 32'd0);
    check("rst_speed", 32'(motor_speed), 32'd0);
    check("rst_strobe", 32'(cmd_strobe), 32'd0);
    check("rst_error", 32'(frame_error), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);

    // Table of frames. Each row's expected outputs follow from the row before it.
    for (int i = 0; i < 9; i++) begin
      obstacle = vecs[i].obs;
      send_frame(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
      check($sformatf("v%0d_dir", i), 32'(motor_dir), 32'(vecs[i].exp_dir));
      check($sformatf("v%0d_speed", i), 32'(motor_speed), 32'(vecs[i].exp_spd));
      check($sformatf("v%0d_strobe", i), 32'(cmd_strobe), 32'(vecs[i].exp_strobe));
      check($sformatf("v%0d_error", i), 32'(frame_error), 32'(vecs[i].exp_err));
      tick();
      check($sformatf("v%0d_strobe_end", i), 32'(cmd_strobe), 32'd0);
      check($sformatf("v%0d_error_end", i), 32'(frame_error), 32'd0);
    end

    // Obstacle masks forward one cycle later and releases one cycle after it falls.
    obstacle = 1'b0;
    send_frame(8'hA5, 8'h01, 8'h80, 8'h81);
    check("obs_fwd_dir", 32'(motor_dir), 32'd1);
    obstacle = 1'b1;
    tick();
    check("obs_on_dir", 32'(motor_dir), 32'd0);
    check("obs_on_speed", 32'(motor_speed), 32'd0);
    obstacle = 1'b0;
    tick();
    check("obs_off_dir", 32'(motor_dir), 32'd1);
    check("obs_off_speed", 32'(motor_speed), 32'h80);

    // A forward frame applied under obstacle is stored and appears when the obstacle clears.
    obstacle = 1'b1;
    send_frame(8'hA5, 8'h01, 8'h40, 8'h41);
    check("obs_apply_strobe", 32'(cmd_strobe), 32'd1);
    check("obs_apply_dir", 32'(motor_dir), 32'd0);
    check("obs_apply_speed", 32'(motor_speed), 32'd0);
    obstacle = 1'b0;
    tick();
    check("obs_release_dir", 32'(motor_dir), 32'd1);
    check("obs_release_speed", 32'(motor_speed), 32'h40);

    // A header byte held valid for 100 cycles is accepted only once.
    n = 0;
    while (!byte_ready && n < 10) begin
      tick();
      n++;
    end
    byte_data  = 8'hA5;
    byte_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_50);
      if (byte_ready) acc++;
      tick();
    end
    check("held_accepts", 32'(acc), 32'd1);
    check("held_ready_low", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;
    tick();
    check("held_ready_back", 32'(byte_ready), 32'd1);
    send_byte(8'h02);
    send_byte(8'h80);
    send_byte(8'h82);
    check("held_frame_dir", 32'(motor_dir), 32'd2);
    check("held_frame_speed", 32'(motor_speed), 32'h80);

    // Reset in the middle of a frame drops it, and the trailing bytes are ignored.
    send_byte(8'hA5);
    send_byte(8'h01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_dir", 32'(motor_dir), 32'd0);
    send_byte(8'h80);
    send_byte(8'h81);
    check("mid_rst_strobe", 32'(cmd_strobe), 32'd0);
    check("mid_rst_error", 32'(frame_error), 32'd0);
    check("mid_rst_dir2", 32'(motor_dir), 32'd0);
    check("mid_rst_speed2", 32'(motor_speed), 32'd0);
    send_frame(8'hA5, 8'h04, 8'h10, 8'h14);
    check("wd_frame_dir", 32'(motor_dir), 32'd4);
    check("wd_frame_speed", 32'(motor_speed), 32'h10);
    check("wd_frame_timeout", 32'(timeout), 32'd0);

`ifdef CMD_WATCHDOG_EN
    // Measure how many cycles pass from the apply cycle until the watchdog fires.
    n = 0;
    while (!timeout && n < 300) begin
      tick();
      n++;
    end
    check("wd_fired", 32'(timeout), 32'd1);
    check("wd_latency_ok", 32'((n >= 99) && (n <= 102)), 32'd1);
    check("wd_dir", 32'(motor_dir), 32'd0);
    check("wd_speed", 32'(motor_speed), 32'd0);
    send_frame(8'hA5, 8'h03, 8'h20, 8'h23);
    tick();
    check("wd_cleared", 32'(timeout), 32'd0);
    check("wd_new_dir", 32'(motor_dir), 32'd3);
`else
    // Without the watchdog the command persists through a long idle period.
    for (int c = 0; c < 200; c++) tick();
    check("nowd_timeout", 32'(timeout), 32'd0);
    check("nowd_dir", 32'(motor_dir), 32'd4);
    check("nowd_speed", 32'(motor_speed), 32'h10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
